// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit register with valid/ready load, stall enable and gapless streaming.
// Optional even-parity trailer bit enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_load_valid,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_load_ready,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  output logic             o_done,
  output logic             o_busy
);

`ifdef PISO_PARITY_EN
  localparam int unsigned CNT_W    = $clog2(WIDTH + 1);
  localparam int unsigned CNT_LOAD = WIDTH;
`else
  localparam int unsigned CNT_W    = $clog2(WIDTH);
  localparam int unsigned CNT_LOAD = WIDTH - 1;
`endif

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_ser_out;
  logic             r_ser_valid;
  logic             r_done;

  logic [0:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic             w_ser_out_nxt;
  logic             w_ser_valid_nxt;
  logic             w_done_nxt;
  logic             w_accept;
  logic             w_din_first;
  logic [WIDTH-1:0] w_din_rest;
  logic             w_shreg_first;
  logic [WIDTH-1:0] w_shreg_rest;
  logic             w_next_bit;

`ifdef PISO_PARITY_EN
  logic r_par;
  logic w_par_nxt;
`endif

  // Ready also during the last bit of a frame so words can stream with no gap.
  assign o_load_ready = i_en && ((r_state == S_IDLE) || (r_state == S_SHIFT && r_cnt == '0));
  assign w_accept     = i_load_valid && o_load_ready;

  // Bit-order selection for both a fresh word and the in-flight shift register.
  assign w_din_first   = MSB_FIRST ? i_din[WIDTH-1] : i_din[0];
  assign w_din_rest    = MSB_FIRST ? {i_din[WIDTH-2:0], 1'b0} : {1'b0, i_din[WIDTH-1:1]};
  assign w_shreg_first = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shreg_rest  = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

`ifdef PISO_PARITY_EN
  // The step from cnt==1 to cnt==0 presents the parity trailer instead of a data bit.
  assign w_next_bit = (r_cnt == CNT_W'(1)) ? r_par : w_shreg_first;
`else
  assign w_next_bit = w_shreg_first;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_shreg_nxt     = r_shreg;
    w_ser_out_nxt   = r_ser_out;
    w_ser_valid_nxt = r_ser_valid;
    w_done_nxt      = r_done;
`ifdef PISO_PARITY_EN
    w_par_nxt       = r_par;
`endif
    if (i_en) begin
      if (w_accept) begin
        w_state_nxt     = S_SHIFT;
        w_cnt_nxt       = CNT_W'(CNT_LOAD);
        w_shreg_nxt     = w_din_rest;
        w_ser_out_nxt   = w_din_first;
        w_ser_valid_nxt = 1'b1;
        w_done_nxt      = 1'b0;
`ifdef PISO_PARITY_EN
        w_par_nxt       = ^i_din;
`endif
      end else if (r_state == S_SHIFT && r_cnt != '0) begin
        w_cnt_nxt       = r_cnt - CNT_W'(1);
        w_shreg_nxt     = w_shreg_rest;
        w_ser_out_nxt   = w_next_bit;
        w_ser_valid_nxt = 1'b1;
        w_done_nxt      = (r_cnt == CNT_W'(1));
      end else begin
        w_state_nxt     = S_IDLE;
        w_ser_out_nxt   = 1'b0;
        w_ser_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_ser_out   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_done      <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par       <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shreg     <= w_shreg_nxt;
      r_ser_out   <= w_ser_out_nxt;
      r_ser_valid <= w_ser_valid_nxt;
      r_done      <= w_done_nxt;
`ifdef PISO_PARITY_EN
      r_par       <= w_par_nxt;
`endif
    end
  end

  assign o_ser_out   = r_ser_out;
  assign o_ser_valid = r_ser_valid;
  assign o_done      = r_done;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances, queued expected bits.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en_a, lv_a, ready_a, out_a, valid_a, done_a, busy_a;
  logic en_b, lv_b, ready_b, out_b, valid_b, done_b, busy_b;
  logic [7:0] din_a, din_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] q_a[$];
  logic [1:0] q_b[$];
  logic [1:0] e_a, e_b;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_load_valid(lv_a), .i_din(din_a),
    .o_load_ready(ready_a), .o_ser_out(out_a), .o_ser_valid(valid_a),
    .o_done(done_a), .o_busy(busy_a));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_load_valid(lv_b), .i_din(din_b),
    .o_load_ready(ready_b), .o_ser_out(out_b), .o_ser_valid(valid_b),
    .o_done(done_b), .o_busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected entries are {bit, done}; done rides with the final bit of the frame.
  task automatic push_frame(input bit lsb, input logic [7:0] w);
    logic [1:0] ent;
    for (int i = 0; i < 8; i++) begin
      ent = {(lsb ? w[i] : w[7-i]), ((i == 7) && !PAR)};
      if (lsb) q_b.push_back(ent); else q_a.push_back(ent);
    end
    if (PAR) begin
      ent = {^w, 1'b1};
      if (lsb) q_b.push_back(ent); else q_a.push_back(ent);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && en_a) begin
      if (valid_a) begin
        if (q_a.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL a_extra_bit: got bit %0b expected no valid bit at %0t", out_a, $time);
        end else begin
          e_a = q_a.pop_front();
          chk("a_bit", 32'(out_a), 32'(e_a[1]));
          chk("a_done", 32'(done_a), 32'(e_a[0]));
        end
      end else chk("a_done_idle", 32'(done_a), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (!rst && en_b) begin
      if (valid_b) begin
        if (q_b.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b_extra_bit: got bit %0b expected no valid bit at %0t", out_b, $time);
        end else begin
          e_b = q_b.pop_front();
          chk("b_bit", 32'(out_b), 32'(e_b[1]));
          chk("b_done", 32'(done_b), 32'(e_b[0]));
        end
      end else chk("b_done_idle", 32'(done_b), 32'd0);
    end
  end

  // Offer a word, wait (bounded) for ready, then let it be accepted on the next edge.
  task automatic send(input bit lsb, input logic [7:0] w);
    int k;
    if (lsb) begin lv_b = 1'b1; din_b = w; end else begin lv_a = 1'b1; din_a = w; end
    for (k = 0; k < 100; k++) begin
      if (lsb ? ready_b : ready_a) break;
      @(posedge clk); #1;
    end
    if (k == 100) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: got ready=0 expected ready=1 within 100 cycles");
    end
    push_frame(lsb, w);
    @(posedge clk); #1;
    if (lsb) lv_b = 1'b0; else lv_a = 1'b0;
  endtask

  task automatic drain_and_idle(input bit lsb);
    int k;
    for (k = 0; k < 200; k++) begin
      if ((lsb ? q_b.size() : q_a.size()) == 0) break;
      @(posedge clk); #1;
    end
    if (k == 200) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d pending bits expected 0", lsb ? q_b.size() : q_a.size());
    end
    chk("idle_valid", 32'(lsb ? valid_b : valid_a), 32'd0);
    chk("idle_busy", 32'(lsb ? busy_b : busy_a), 32'd0);
    chk("idle_out", 32'(lsb ? out_b : out_a), 32'd0);
  endtask

  initial begin
    int span;
    rst = 1'b1; en_a = 1'b1; en_b = 1'b1; lv_a = 1'b0; lv_b = 1'b0; din_a = '0; din_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(out_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready_a), 32'd1);

    // 1: A5 MSB-first
    send(1'b0, 8'hA5);
    chk("t1_busy", 32'(busy_a), 32'd1);
    drain_and_idle(1'b0);

    // 2: 01 LSB-first, din disturbed after accept
    send(1'b1, 8'h01);
    @(posedge clk); #1;
    din_b = 8'hFF;
    drain_and_idle(1'b1);

    // 3: F0 then 0F gapless with load_valid held
    push_frame(1'b0, 8'hF0);
    push_frame(1'b0, 8'h0F);
    lv_a = 1'b1; din_a = 8'hF0;
    while (!ready_a) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    din_a = 8'h0F;
    for (int i = 1; i <= (PAR ? 18 : 16); i++) begin
      if (i == (PAR ? 10 : 9)) begin
        chk("t3_second_accepted", 32'(busy_a), 32'd1);
        lv_a = 1'b0;
      end
      chk("t3_no_gap", 32'(valid_a), 32'd1);
      @(posedge clk); #1;
    end
    drain_and_idle(1'b0);

    // 4: stall 3 cycles while bit 3 of C3 is on the wire
    send(1'b0, 8'hC3);
    repeat (2) begin @(posedge clk); #1; end
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_out", 32'(out_a), 32'd0);
      chk("t4_stall_valid", 32'(valid_a), 32'd1);
      chk("t4_stall_ready", 32'(ready_a), 32'd0);
      @(posedge clk); #1;
    end
    en_a = 1'b1;
    span = 0;
    while (valid_a && span < 20) begin span++; @(posedge clk); #1; end
    chk("t4_resume_span", 32'(span), PAR ? 32'd7 : 32'd6);
    drain_and_idle(1'b0);

    // 5: async reset in the middle of bit 5, no clock edge involved
    send(1'b0, 8'h3C);
    repeat (4) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    q_a.delete();
    #1;
    chk("t5_rst_out", 32'(out_a), 32'd0);
    chk("t5_rst_valid", 32'(valid_a), 32'd0);
    chk("t5_rst_done", 32'(done_a), 32'd0);
    chk("t5_rst_busy", 32'(busy_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_no_done", 32'(done_a), 32'd0);
    send(1'b0, 8'h96);
    drain_and_idle(1'b0);

    // 6: 07 (odd weight, parity trailer 1 when enabled)
    send(1'b0, 8'h07);
    drain_and_idle(1'b0);

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmit register. It is the transmit-direction counterpart to the team's D-flop capture and shift-in blocks.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock, framed by `ser_valid`.
- Supports gapless back-to-back words and a stall input.
- Sits between a parallel producer and any single-wire serial consumer, such as a SIPO deserializer.

Parameters:
- WIDTH, 8, data word width; legal range 2..32
- MSB_FIRST, 1, 1 = din[WIDTH-1] is sent first; 0 = din[0] is sent first

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  shift enable; 0 freezes all state and outputs
- load_valid  input  1  producer has a word on din
- din  input  WIDTH  parallel word; sampled on accept
- load_ready  output  1  serializer can accept a word this cycle
- ser_out  output  1  serial data bit, registered
- ser_valid  output  1  ser_out carries a valid bit, registered
- done  output  1  one-cycle pulse coinciding with the last bit of a frame, registered
- busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, shift register=0, bit counter=0, ser_out=0, ser_valid=0, done=0. Reset asserted mid-frame aborts the frame immediately; no partial completion and no done pulse.
- States:
  - IDLE: nothing being sent.
  - SHIFT: frame in progress.
- Combinational ready:
  - load_ready = en && (state==IDLE || (state==SHIFT && cnt==0)).
  - Ready is also asserted during the last bit of a frame, which enables gapless streaming.
- Accept: load_valid && load_ready at a rising edge (cycle T).
  - Capture din.
  - cnt <= WIDTH-1.
  - state <= SHIFT.
  - First bit appears on ser_out with ser_valid=1 in cycle T+1.
- SHIFT, en=1: each edge presents the next bit and decrements cnt. Frame bits occupy cycles T+1..T+WIDTH.
- done=1 exactly in cycle T+WIDTH, together with the last bit.
- End of frame (cnt==0, en=1):
  - If a new accept occurs in the same cycle: next word's first bit follows in the very next cycle, ser_valid stays 1, state stays SHIFT.
  - Otherwise: state returns to IDLE and ser_valid=0 in the next cycle.
- IDLE: ser_valid=0, done=0; ser_out holds 0.
- en=0: all registers hold, including ser_out, ser_valid and done, so a stalled done remains high. load_ready=0, so no accept is possible. Resuming continues with the held bit's successor; no bits are lost or duplicated.
- load_valid while load_ready=0 is ignored. The producer must hold the word until ready.
- din changes after accept have no effect on the frame.
- Bit order:
  - MSB_FIRST=1: shift left, emit register MSB.
  - MSB_FIRST=0: shift right, emit LSB.
- Counter width is $clog2(WIDTH) bits. It never wraps below 0; the cnt==0 branch always reloads the counter or exits to IDLE.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - After the WIDTH data bits, one extra even-parity bit (XOR of the accepted word) is sent with ser_valid=1.
  - Frame length is WIDTH+1 cycles; done and the load_ready window move to the parity cycle.
  - The counter is loaded with WIDTH instead of WIDTH-1.
- Undefined: no parity bit; frame length is WIDTH cycles as above.

Test Plan:
1. WIDTH=8, MSB_FIRST=1, accept din=8'hA5 at T → ser_out over T+1..T+8 = 1,0,1,0,0,1,0,1; ser_valid=1 throughout; done=1 only at T+8; state=IDLE and ser_valid=0 at T+9.
2. MSB_FIRST=0, din=8'h01 → ser_out = 1 then seven 0s; din changed to 8'hFF at T+2 has no effect on the frame.
3. Back-to-back 8'hF0 then 8'h0F, load_valid held → 16 consecutive valid bits 1111000000001111 with no gap; two done pulses, at bit 8 and bit 16.
4. Drop en for 3 cycles after bit 3 of 8'hC3 → ser_out/ser_valid frozen and load_ready=0 during the stall; remaining bits resume in order; total frame spans 11 cycles.
5. Assert rst asynchronously mid-edge at bit 5 → outputs return to 0 immediately with no clock edge; no done pulse; next accept after rst release sends a full clean frame.
6. With PISO_PARITY_EN defined, din=8'h07 → 9-bit frame 0,0,0,0,0,1,1,1,1 (parity=1); done on the 9th bit.
